pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer and fetch controller for the KGP_RISC core. It owns the PC register and runs instruction fetch against a variable-latency instruction memory. It holds each fetched instruction stable while the datapath executes it, then loads the next PC chosen by the branch mechanism. It sits between instruction memory, the decode/execute datapath and the next-address selection logic, and it also counts retired instructions.

## Interface
- ADDR_W, 13, instruction address width; matches the next-address selector output
- DATA_W, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level enable; the sequencer starts or continues fetching while it is high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  fetch address; equals pc whenever imem_req=1
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  DATA_W  instruction word, valid only with imem_ack
- instr  out  DATA_W  latched instruction presented to decode
- instr_valid  out  1  high for the whole time instr is under execution
- pc  out  ADDR_W  address of the current or pending instruction
- pc_plus1  out  ADDR_W  pc+1 modulo 2^ADDR_W; feeds the sequential-address input of the next-address selector
- exec_done  in  1  datapath has completed the current instruction; next_pc and halt are valid this cycle
- next_pc  in  ADDR_W  next address from the branch/jump selector
- halt  in  1  current instruction is a halt; sampled only with exec_done
- halted  out  1  sequencer is in HALT
- retired  out  16  count of completed instructions

## Operation
- States: IDLE, FETCH, EXEC, HALT (binary-encoded register). Outputs are decoded from the state register.
- Reset (asynchronous) forces the following values:
  - state=IDLE, pc=RESET_PC, instr=0, retired=0
  - all request and valid outputs low
- IDLE:
  - imem_req=0, instr_valid=0.
  - Moves to FETCH when run=1.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - When imem_ack=1: latch instr<=imem_rdata and move to EXEC.
  - When imem_ack=0: hold state; imem_req and imem_addr stay stable with no glitches.
  - run is ignored here; an issued fetch always completes.
- EXEC:
  - instr_valid=1; instr and pc are held.
  - When exec_done=1 and halt=1: retired+1, pc unchanged, move to HALT.
  - When exec_done=1 and halt=0: retired+1, pc<=next_pc. Move to FETCH if run=1, else IDLE.
- HALT:
  - halted=1; no requests.
  - Moves to IDLE when run=0. pc is kept, so a later run resumes from the halt address.
- imem_ack outside FETCH and exec_done outside EXEC are ignored and cause no state change.
- pc_plus1 is combinational pc+1; it wraps 0x1FFF->0x0000 at ADDR_W=13.
- retired wraps 0xFFFF->0x0000.
- instr keeps its last value outside EXEC and is not cleared on a new fetch until ack arrives.

## Timing
- imem_req is asserted in the first cycle of FETCH, and imem_ack is accepted in that same cycle. Minimum fetch occupancy is therefore 1 cycle.
- Latch timing: instr and instr_valid update on the edge that samples imem_ack. Decode sees the new instruction in the next cycle.
- Minimum throughput is 2 cycles per instruction (1 FETCH + 1 EXEC), with ack and exec_done both asserted on their first cycle.
- After reset release, the first imem_req appears 1 cycle after run is sampled high (IDLE->FETCH).
- pc changes only on the edge that samples exec_done in EXEC (or on reset). next_pc must be stable in that cycle.
- Reset mid-fetch: the request drops immediately (asynchronous). A late imem_ack after reset is ignored because the state is IDLE.

## Test plan
- Reset/start: hold rst_n=0, then release with run=0 -> pc=0x0000, imem_req=0 indefinitely. Raise run -> imem_req=1, imem_addr=0x0000 one cycle later.
- Sequential flow: zero-latency ack with rdata=0xA5A50001, then exec_done with next_pc=pc_plus1 -> instr=0xA5A50001, pc steps 0,1,2. Period is 2 cycles per instruction; retired increments by 1 per instruction.
- Memory stall and branch: hold imem_ack low for 5 cycles -> imem_req and imem_addr stable throughout. Then exec_done with next_pc=0x0123 -> next imem_addr=0x0123.
- Halt and resume: exec_done with halt=1 at pc=0x0040 -> halted=1, pc stays 0x0040, retired+1. Drop run -> IDLE. Raise run -> fetch from 0x0040.
- Wrap and ignores: pc=0x1FFF -> pc_plus1=0x0000. Pulse exec_done during FETCH and imem_ack during EXEC -> no state or pc change.
- Reset mid-operation: assert rst_n=0 while in FETCH awaiting ack -> imem_req falls in the same cycle, pc=RESET_PC, retired=0. An ack arriving after release with run=0 is ignored.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer (master) and the
// instruction memory (slave).
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_sequencer.sv
// KGP_RISC program-counter sequencer: owns the PC, fetches from a
// variable-latency instruction memory, holds the instruction during execution.
module pc_sequencer #(
  parameter int unsigned            ADDR_W   = 13,
  parameter int unsigned            DATA_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  pc_sequencer_if.master      imem,
  output logic [DATA_W-1:0]   instr,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus1,
  input  logic                exec_done,
  input  logic [ADDR_W-1:0]   next_pc,
  input  logic                halt,
  output logic                halted,
  output logic [15:0]         retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Ack is only honoured in FETCH and exec_done only in EXEC.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + 16'd1;
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = run ? FETCH : IDLE;
          end
        end
      end
      HALT: begin
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem.req    = (state_q == FETCH);
    imem.addr   = pc_q;
    instr_valid = (state_q == EXEC);
    halted      = (state_q == HALT);
  end

  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic              exec_done;
  logic [ADDR_W-1:0] next_pc;
  logic              halt;
  logic              halted;
  logic [15:0]       retired;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pc_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (13'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem        (bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .exec_done   (exec_done),
    .next_pc     (next_pc),
    .halt        (halt),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    exec_done = 1'b0;
    next_pc   = '0;
    halt      = 1'b0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    @(negedge clk);
    @(negedge clk);

    check_eq("rst_pc",      32'(pc), 32'h0);
    check_eq("rst_req",     32'(bus.req), 32'h0);
    check_eq("rst_valid",   32'(instr_valid), 32'h0);
    check_eq("rst_halted",  32'(halted), 32'h0);
    check_eq("rst_retired", 32'(retired), 32'h0);
    check_eq("rst_instr",   instr, 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_req", 32'(bus.req), 32'h0);
    end
    check_eq("idle_pc", 32'(pc), 32'h0);

    // Start: first request one cycle after run sampled.
    run = 1'b1;
    tick();
    check_eq("start_req",  32'(bus.req), 32'h1);
    check_eq("start_addr", 32'(bus.addr), 32'h0);

    // Sequential flow with zero-latency ack and immediate exec_done.
    bus.ack = 1'b1; bus.rdata = 32'hA5A5_0001;
    tick();
    bus.ack = 1'b0;
    check_eq("seq0_valid", 32'(instr_valid), 32'h1);
    check_eq("seq0_instr", instr, 32'hA5A5_0001);
    check_eq("seq0_req",   32'(bus.req), 32'h0);
    check_eq("seq0_pc1",   32'(pc_plus1), 32'h1);
    exec_done = 1'b1; next_pc = 13'h0001;
    tick();
    exec_done = 1'b0;
    check_eq("seq1_addr",    32'(bus.addr), 32'h1);
    check_eq("seq1_req",     32'(bus.req), 32'h1);
    check_eq("seq1_retired", 32'(retired), 32'h1);
    bus.ack = 1'b1; bus.rdata = 32'hA5A5_0002;
    tick();
    bus.ack = 1'b0;
    check_eq("seq1_instr", instr, 32'hA5A5_0002);
    exec_done = 1'b1; next_pc = 13'h0002;
    tick();
    exec_done = 1'b0;
    check_eq("seq2_addr",    32'(bus.addr), 32'h2);
    check_eq("seq2_retired", 32'(retired), 32'h2);

    // Memory stall; an exec_done pulse during FETCH must be ignored.
    for (int i = 0; i < 5; i++) begin
      exec_done = (i == 2);
      next_pc   = 13'h0555;
      tick();
      check_eq("stall_req",  32'(bus.req), 32'h1);
      check_eq("stall_addr", 32'(bus.addr), 32'h2);
    end
    exec_done = 1'b0;
    check_eq("stall_retired", 32'(retired), 32'h2);
    check_eq("stall_instr",   instr, 32'hA5A5_0002);
    bus.ack = 1'b1; bus.rdata = 32'h0000_1111;
    tick();
    // Stray ack during EXEC must not reload instr or change state.
    bus.rdata = 32'hDEAD_BEEF;
    tick();
    bus.ack = 1'b0;
    check_eq("ign_ack_instr", instr, 32'h0000_1111);
    check_eq("ign_ack_valid", 32'(instr_valid), 32'h1);
    check_eq("ign_ack_pc",    32'(pc), 32'h2);
    exec_done = 1'b1; next_pc = 13'h0123;
    tick();
    exec_done = 1'b0;
    check_eq("branch_addr",    32'(bus.addr), 32'h123);
    check_eq("branch_retired", 32'(retired), 32'h3);

    // Branch to 0x0040, then halt there.
    bus.ack = 1'b1; bus.rdata = 32'h0000_2222;
    tick();
    bus.ack = 1'b0;
    exec_done = 1'b1; next_pc = 13'h0040;
    tick();
    exec_done = 1'b0;
    check_eq("to40_addr", 32'(bus.addr), 32'h40);
    bus.ack = 1'b1; bus.rdata = 32'hFFFF_0000;
    tick();
    bus.ack = 1'b0;
    exec_done = 1'b1; halt = 1'b1; next_pc = 13'h0999;
    tick();
    exec_done = 1'b0; halt = 1'b0;
    check_eq("halt_halted",  32'(halted), 32'h1);
    check_eq("halt_pc",      32'(pc), 32'h40);
    check_eq("halt_retired", 32'(retired), 32'h5);
    check_eq("halt_req",     32'(bus.req), 32'h0);
    tick();
    check_eq("halt_hold", 32'(halted), 32'h1);
    run = 1'b0;
    tick();
    check_eq("unhalt_halted", 32'(halted), 32'h0);
    check_eq("unhalt_req",    32'(bus.req), 32'h0);
    run = 1'b1;
    tick();
    check_eq("resume_req",  32'(bus.req), 32'h1);
    check_eq("resume_addr", 32'(bus.addr), 32'h40);

    // PC wrap at top of address space.
    bus.ack = 1'b1; bus.rdata = 32'h1234_5678;
    tick();
    bus.ack = 1'b0;
    exec_done = 1'b1; next_pc = 13'h1FFF;
    tick();
    exec_done = 1'b0;
    check_eq("wrap_pc",  32'(pc), 32'h1FFF);
    check_eq("wrap_pc1", 32'(pc_plus1), 32'h0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    exec_done = 1'b1; next_pc = 13'h0000; run = 1'b0;
    tick();
    exec_done = 1'b0;
    check_eq("wrap_idle_req", 32'(bus.req), 32'h0);
    check_eq("wrap_idle_pc",  32'(pc), 32'h0);
    check_eq("wrap_retired",  32'(retired), 32'h7);

    // Reset while a fetch is outstanding.
    run = 1'b1;
    next_pc = 13'h0077;
    tick();
    check_eq("midrst_req_pre", 32'(bus.req), 32'h1);
    run = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_req",     32'(bus.req), 32'h0);
    check_eq("midrst_pc",      32'(pc), 32'h0);
    check_eq("midrst_retired", 32'(retired), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ack = 1'b1; bus.rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    bus.ack = 1'b0;
    check_eq("late_ack_req",   32'(bus.req), 32'h0);
    check_eq("late_ack_valid", 32'(instr_valid), 32'h0);
    check_eq("late_ack_instr", instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
